phase_accumulator: RTL and testbench

// - NCO front end that sits directly upstream of the sintable lookup stage.
// - Accumulates a frequency tuning word once per sample strobe.
// - Emits the top PHASE_W bits, plus a phase offset, as the table index.
// - Frequency changes are double-buffered and applied only at phase wrap, so the output tone stays continuous.

---
 rtl/nco_pkg.sv | 17 +
 rtl/phase_accumulator_if.sv | 45 ++++
 rtl/freq_shadow_reg.sv | 81 ++++++++
 rtl/phase_accumulator.sv | 80 ++++++++
 tb/tb_phase_accumulator.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/nco_pkg.sv
// Shared NCO definitions. The sintable stage imports the same package,
// so the phase index width used here always matches its input width.
package nco_pkg;

    localparam int unsigned NCO_ACC_W   = 24;
    localparam int unsigned NCO_PHASE_W = 8;

    localparam logic [NCO_ACC_W-1:0] NCO_RESET_FREQ = 24'h010000;

    // Source selected for the active tuning word on a given cycle
    typedef enum logic [1:0] {
        FREQ_HOLD,
        FREQ_APPLY_SHADOW,
        FREQ_APPLY_NEW
    } freq_sel_e;

endpackage

// File: rtl/phase_accumulator_if.sv
// Control/data bundle between the NCO front end and its controller.
// Signal names keep the i_/o_ prefixes as seen from the accumulator.
interface phase_accumulator_if
    import nco_pkg::*;
#(
    parameter int unsigned ACC_W   = NCO_ACC_W,
    parameter int unsigned PHASE_W = NCO_PHASE_W
);

    logic               i_ce;
    logic               i_sync_clr;
    logic               i_freq_wr;
    logic [ACC_W-1:0]   i_freq;
    logic [PHASE_W-1:0] i_phase_ofs;

    logic [PHASE_W-1:0] o_phase;
    logic               o_valid;
    logic               o_wrap;
    logic               o_freq_busy;

    modport master (
        output i_ce,
        output i_sync_clr,
        output i_freq_wr,
        output i_freq,
        output i_phase_ofs,
        input  o_phase,
        input  o_valid,
        input  o_wrap,
        input  o_freq_busy
    );

    modport slave (
        input  i_ce,
        input  i_sync_clr,
        input  i_freq_wr,
        input  i_freq,
        input  i_phase_ofs,
        output o_phase,
        output o_valid,
        output o_wrap,
        output o_freq_busy
    );

endinterface

// File: rtl/freq_shadow_reg.sv
// Double-buffered tuning word. Writes land in the shadow register and are
// only moved into the active word at an accumulator wrap or a sync clear,
// which keeps the generated tone phase-continuous.
module freq_shadow_reg
    import nco_pkg::*;
#(
    parameter int unsigned      ACC_W      = NCO_ACC_W,
    parameter logic [ACC_W-1:0] RESET_FREQ = ACC_W'(NCO_RESET_FREQ)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_step,
    input  logic             i_carry,
    input  logic             i_sync_clr,
    input  logic             i_freq_wr,
    input  logic [ACC_W-1:0] i_freq,
    output logic [ACC_W-1:0] o_freq_act,
    output logic             o_pend
);

    logic [ACC_W-1:0] shadow_q, shadow_d;
    logic [ACC_W-1:0] freq_act_q, freq_act_d;
    logic             pend_q, pend_d;
    freq_sel_e        sel;

    // Decide where the active word comes from this cycle
    always_comb begin
        sel = FREQ_HOLD;
        if (i_sync_clr) begin
            if (i_freq_wr) begin
                sel = FREQ_APPLY_NEW;
            end else if (pend_q) begin
                sel = FREQ_APPLY_SHADOW;
            end
        end else if (i_step && i_carry && pend_q) begin
            sel = FREQ_APPLY_SHADOW;
        end
    end

    // Next-state for shadow, active word and pending flag
    always_comb begin
        shadow_d   = i_freq_wr ? i_freq : shadow_q;
        freq_act_d = freq_act_q;
        pend_d     = pend_q;
        unique case (sel)
            FREQ_HOLD: begin
                pend_d = pend_q | i_freq_wr;
            end
            FREQ_APPLY_SHADOW: begin
                // A write coinciding with a wrap-apply stays pending for the next wrap
                freq_act_d = shadow_q;
                pend_d     = i_freq_wr & ~i_sync_clr;
            end
            FREQ_APPLY_NEW: begin
                freq_act_d = i_freq;
                pend_d     = 1'b0;
            end
            default: begin
                freq_act_d = freq_act_q;
                pend_d     = pend_q;
            end
        endcase
    end

    // State registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            shadow_q   <= '0;
            freq_act_q <= RESET_FREQ;
            pend_q     <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            freq_act_q <= freq_act_d;
            pend_q     <= pend_d;
        end
    end

    assign o_freq_act = freq_act_q;
    assign o_pend     = pend_q;

endmodule

// File: rtl/phase_accumulator.sv
// NCO front end: accumulates the active tuning word on each sample strobe
// and emits the top PHASE_W bits plus an offset as the sintable index.
module phase_accumulator
    import nco_pkg::*;
#(
    parameter int unsigned      ACC_W      = NCO_ACC_W,
    parameter int unsigned      PHASE_W    = NCO_PHASE_W,
    parameter logic [ACC_W-1:0] RESET_FREQ = ACC_W'(NCO_RESET_FREQ)
) (
    input logic                i_clk,
    input logic                i_reset,
    phase_accumulator_if.slave bus
);

    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;

    logic [ACC_W:0]     sum;
    logic               step;
    logic [ACC_W-1:0]   freq_act;
    logic               pend;

    freq_shadow_reg #(
        .ACC_W      (ACC_W),
        .RESET_FREQ (RESET_FREQ)
    ) u_freq_shadow (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_step     (step),
        .i_carry    (sum[ACC_W]),
        .i_sync_clr (bus.i_sync_clr),
        .i_freq_wr  (bus.i_freq_wr),
        .i_freq     (bus.i_freq),
        .o_freq_act (freq_act),
        .o_pend     (pend)
    );

    // Accumulator step, offset add and output next-state; sync clear wins over the strobe
    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, freq_act};
        step    = bus.i_ce & ~bus.i_sync_clr;
        acc_d   = acc_q;
        phase_d = phase_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        if (bus.i_sync_clr) begin
            acc_d   = '0;
            phase_d = bus.i_phase_ofs;
            valid_d = 1'b1;
        end else if (bus.i_ce) begin
            acc_d   = sum[ACC_W-1:0];
            phase_d = sum[ACC_W-1 -: PHASE_W] + bus.i_phase_ofs;
            valid_d = 1'b1;
            wrap_d  = sum[ACC_W];
        end
    end

    // Accumulator and registered outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            acc_q   <= '0;
            phase_q <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.o_phase     = phase_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_wrap      = wrap_q;
    assign bus.o_freq_busy = pend;

endmodule

// File: tb/tb_phase_accumulator.sv
// Scoreboard bench for phase_accumulator against an arithmetic NCO model.
module tb_phase_accumulator;

    localparam int unsigned ACC_W   = 24;
    localparam int unsigned PHASE_W = 8;
    localparam longint unsigned ACC_MOD  = 64'h1000000;
    localparam longint unsigned RST_FREQ = 64'h010000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    phase_accumulator_if #(.ACC_W(ACC_W), .PHASE_W(PHASE_W)) bus ();

    phase_accumulator #(
        .ACC_W      (ACC_W),
        .PHASE_W    (PHASE_W),
        .RESET_FREQ (24'h010000)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct {
        int unsigned cyc;
        logic [7:0]  phase;
        logic        wrap;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;
    bit mon_en = 0;

    // reference model state (plain integers)
    longint unsigned m_acc, m_freq, m_shadow;
    bit m_pend;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0;
        m_freq = RST_FREQ;
        m_shadow = 0;
        m_pend = 0;
    endtask

    // One stimulus cycle: drive at negedge, advance the model, queue the expected output
    task automatic cycle(input bit ce, input bit clr, input bit wr,
                         input longint unsigned freq, input int unsigned ofs);
        longint unsigned s;
        bit carry;
        exp_t e;
        @(negedge clk);
        bus.i_ce        = ce;
        bus.i_sync_clr  = clr;
        bus.i_freq_wr   = wr;
        bus.i_freq      = freq[23:0];
        bus.i_phase_ofs = ofs[7:0];
        if (clr) begin
            m_acc = 0;
            if (wr) begin
                m_freq = freq;
                m_shadow = freq;
                m_pend = 0;
            end else if (m_pend) begin
                m_freq = m_shadow;
                m_pend = 0;
            end
            e.cyc = cyc + 1;
            e.phase = ofs[7:0];
            e.wrap = 1'b0;
            q.push_back(e);
        end else begin
            if (ce) begin
                s = m_acc + m_freq;
                carry = (s >= ACC_MOD);
                m_acc = s % ACC_MOD;
                e.cyc = cyc + 1;
                e.phase = 8'(((m_acc / 65536) + ofs) % 256);
                e.wrap = carry;
                q.push_back(e);
                if (carry && m_pend) begin
                    m_freq = m_shadow;
                    m_pend = 0;
                end
            end
            if (wr) begin
                m_shadow = freq;
                m_pend = 1;
            end
        end
    endtask

    task automatic run(input int n, input int unsigned ofs);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, ofs);
    endtask

    // Gate the strobe, then pulse reset for one cycle mid-operation
    task automatic mid_reset();
        cycle(0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_phase", bus.o_phase, 0);
        check("rst_valid", bus.o_valid, 0);
        check("rst_wrap", bus.o_wrap, 0);
        check("rst_busy", bus.o_freq_busy, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compare whenever the DUT presents a valid output
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (mon_en && !rst) begin
                if (bus.o_valid) begin
                    if (q.size() == 0) begin
                        check("valid_unexpected", bus.o_valid, 0);
                    end else begin
                        e = q.pop_front();
                        check("valid_cycle", cyc, e.cyc);
                        check("phase", bus.o_phase, e.phase);
                        check("wrap", bus.o_wrap, e.wrap);
                    end
                end else begin
                    if (q.size() > 0 && q[0].cyc <= cyc) begin
                        check("valid_missing", bus.o_valid, 1);
                        void'(q.pop_front());
                    end
                    check("idle_wrap", bus.o_wrap, 0);
                end
                check("busy", bus.o_freq_busy, m_pend);
            end
        end
    end

    initial begin
        int unsigned ofs;
        longint unsigned f;
        bit ce, clr, wr;
        rst = 1'b1;
        bus.i_ce = 0;
        bus.i_sync_clr = 0;
        bus.i_freq_wr = 0;
        bus.i_freq = '0;
        bus.i_phase_ofs = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_phase", bus.o_phase, 0);
        check("reset_valid", bus.o_valid, 0);
        check("reset_wrap", bus.o_wrap, 0);
        check("reset_busy", bus.o_freq_busy, 0);
        rst = 1'b0;
        mon_en = 1;

        // default sweep: 0x01 .. 0xFF, 0x00 with wrap on the 256th step
        run(260, 0);

        // half-rate tuning word applied at the next wrap
        cycle(0, 0, 1, 64'h800000, 0);
        run(300, 0);

        // mid-sweep reset restarts from acc=0 with the reset word
        mid_reset();
        run(20, 0);

        // two writes before the wrap: last one wins
        cycle(1, 0, 1, 64'h020000, 0);
        run(10, 0);
        cycle(1, 0, 1, 64'h040000, 0);
        run(280, 0);

        // phase offset with default word
        mid_reset();
        run(300, 8'h40);

        // sync clear applies the pending word immediately
        cycle(0, 0, 1, 64'h100000, 0);
        cycle(1, 1, 0, 0, 0);
        run(40, 0);

        // sync clear together with a write
        cycle(1, 1, 1, 64'h300000, 8'h10);
        run(20, 8'h10);

        // zero tuning word: phase holds, no wrap
        cycle(0, 0, 1, 0, 0);
        cycle(1, 1, 0, 0, 8'h22);
        run(30, 8'h22);

        // randomized traffic
        ofs = 0;
        for (int i = 0; i < 3000; i++) begin
            ce  = ($urandom % 4) != 0;
            clr = ($urandom % 64) == 0;
            wr  = ($urandom % 24) == 0;
            case ($urandom % 4)
                0: f = 0;
                1: f = $urandom_range(32'h1, 32'h40000);
                default: f = $urandom % 32'h1000000;
            endcase
            if (($urandom % 50) == 0) ofs = $urandom % 256;
            if (($urandom % 700) == 0) mid_reset();
            cycle(ce, clr, wr, f, ofs);
        end

        repeat (3) cycle(0, 0, 0, 0, 0);
        @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
